// File: rtl/exc_recovery_ctrl.sv
`timescale 1ns/1ps
// exc_recovery_ctrl
// Exception recovery sequencer between commit and the pipeline front end.
// An exception at the ROB head starts a fixed sequence:
// flush -> drain -> rename restore -> fetch redirect -> resume.
//
// Optional feature macro: EXC_VECTORED_EN
//   defined     : interrupts taken with mtvec[0]=1 jump to base + cause*4
//   not defined : the trap target is always the mtvec base (mtvec[0] ignored)
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   exc_valid       exception reported at ROB head (accepted only in IDLE)
//   exc_pc          PC of the faulting instruction
//   exc_cause       5-bit exception code
//   exc_intr        event is an interrupt
//   mtvec           trap vector CSR (bit 0 = vectored mode)
//   fu_busy         per-FU in-flight indicator
//   mem_busy        store buffer / LSU still draining
//   restore_done    rename map restore complete
//   redirect_ready  fetch accepts the redirect
//   exc_flush       one-cycle flush pulse
//   rename_restore  level request while restoring the rename map
//   redirect_valid  fetch redirect request
//   redirect_pc     trap target
//   resume          one-cycle resume pulse
//   mepc, mcause    captured faulting PC and cause (MSB = interrupt)
//   busy            high whenever the sequencer is not idle
//   timeout_err     sticky drain-timeout flag, cleared only by reset
module exc_recovery_ctrl #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned N_FU          = 4,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [4:0]      exc_cause,
  input  logic            exc_intr,
  input  logic [XLEN-1:0] mtvec,
  input  logic [N_FU-1:0] fu_busy,
  input  logic            mem_busy,
  input  logic            restore_done,
  input  logic            redirect_ready,
  output logic            exc_flush,
  output logic            rename_restore,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            resume,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic            busy,
  output logic            timeout_err
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CAUSE_W = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_DRAIN    = 3'd2,
    S_RESTORE  = 3'd3,
    S_REDIRECT = 3'd4,
    S_RESUME   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_drain_idle;
  logic               w_drain_expired;
  logic               w_timeout_set;
  logic               w_accept;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_target;
  logic               w_unused;

  // Drain is complete once no FU or memory activity remains
  assign w_drain_idle    = (fu_busy == '0) && !mem_busy;
  assign w_cnt_inc       = r_drain_cnt + CNT_W'(1);
  // The counter holds the number of completed stalled DRAIN cycles, so
  // comparing its incremented value exits after exactly DRAIN_TIMEOUT cycles
  assign w_drain_expired = (w_cnt_inc == CNT_W'(DRAIN_TIMEOUT));
  assign w_accept        = (r_state == S_IDLE) && exc_valid;

  // Trap target: base address with the mode bits cleared
  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef EXC_VECTORED_EN
  logic [XLEN-1:0] w_vec_off;
  assign w_vec_off = XLEN'({exc_cause, 2'b00});
  assign w_target  = (mtvec[0] && exc_intr) ? (w_base + w_vec_off) : w_base;
`else
  assign w_target  = w_base;
`endif

  // Low mode bits of mtvec are not part of the target address
  assign w_unused = ^mtvec[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (exc_valid) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_idle) begin
          w_state_nxt = S_RESTORE;
        end else if (w_drain_expired) begin
          w_state_nxt   = S_RESTORE;
          w_timeout_set = 1'b1;
        end
      end
      S_RESTORE: begin
        if (restore_done) begin
          w_state_nxt = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // redirect_valid is asserted throughout this state, so the
        // handshake completes on redirect_ready alone
        if (redirect_ready) begin
          w_state_nxt = S_RESUME;
        end
      end
      S_RESUME: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Drain cycle counter, cleared on the way into DRAIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == S_FLUSH) begin
      r_drain_cnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= w_cnt_inc;
    end
  end

  // Exception capture; values hold until the next accepted exception
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mepc        <= '0;
      mcause      <= '0;
      redirect_pc <= '0;
    end else if (w_accept) begin
      mepc        <= exc_pc;
      mcause      <= {exc_intr, {(XLEN-CAUSE_W-1){1'b0}}, exc_cause};
      redirect_pc <= w_target;
    end
  end

  // Control outputs registered from the next state so each one is
  // aligned with the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_flush      <= 1'b0;
      rename_restore <= 1'b0;
      redirect_valid <= 1'b0;
      resume         <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      exc_flush      <= (w_state_nxt == S_FLUSH);
      rename_restore <= (w_state_nxt == S_RESTORE);
      redirect_valid <= (w_state_nxt == S_REDIRECT);
      resume         <= (w_state_nxt == S_RESUME);
      busy           <= (w_state_nxt != S_IDLE);
      timeout_err    <= timeout_err | w_timeout_set;
    end
  end

endmodule
